// File: rtl/ppi_bus_sequencer.sv
// ppi_bus_sequencer: two-requester round-robin host controller for an 8255 PPI.
// Each accepted command runs as one bus cycle (setup, RD/WR strobe, hold)
// followed by a single-cycle response pulse. Reads of the control address
// are rejected with an error response and never touch the PPI pins.
module ppi_bus_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_rd,
    input  logic [1:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_rd,
    input  logic [1:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       ppi_cs_n,
    output logic       ppi_rd_n,
    output logic       ppi_wr_n,
    output logic       ppi_a1,
    output logic       ppi_a0,
    output logic [7:0] ppi_d_out,
    output logic       ppi_d_oe,
    input  logic [7:0] ppi_d_in,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       cmd_rd_q, cmd_rd_d;
    logic       cmd_id_q, cmd_id_d;
    logic [7:0] cap_q, cap_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a1_q, a1_d;
    logic       a0_q, a0_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;

    logic       grant;
    logic       accept;
    logic       sel_rd;
    logic [1:0] sel_addr;
    logic [7:0] sel_wdata;

    // Round-robin arbitration: a lone requester wins, on contention the one not served last wins
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        accept     = (state_q == ST_IDLE) && !Reset && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        sel_rd     = grant ? req1_rd    : req0_rd;
        sel_addr   = grant ? req1_addr  : req0_addr;
        sel_wdata  = grant ? req1_wdata : req0_wdata;
    end

    // Bus-cycle sequencing: next state, counter and registered pin/response values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        cmd_rd_d     = cmd_rd_q;
        cmd_id_d     = cmd_id_q;
        cap_d        = cap_q;
        cs_n_d       = cs_n_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        a1_d         = a1_q;
        a0_d         = a0_q;
        d_out_d      = d_out_q;
        d_oe_d       = d_oe_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    cmd_rd_d     = sel_rd;
                    cmd_id_d     = grant;
                    if (sel_rd && (sel_addr == 2'd3)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                        cs_n_d  = 1'b0;
                        a1_d    = sel_addr[1];
                        a0_d    = sel_addr[0];
                        d_oe_d  = !sel_rd;
                        d_out_d = sel_rd ? 8'h00 : sel_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                    if (cmd_rd_q) begin
                        rd_n_d = 1'b0;
                    end else begin
                        wr_n_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    if (cmd_rd_q) begin
                        cap_d = ppi_d_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    cs_n_d      = 1'b1;
                    a1_d        = 1'b0;
                    a0_d        = 1'b0;
                    d_out_d     = 8'h00;
                    d_oe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cmd_id_q;
                    rsp_rdata_d = cmd_rd_q ? cap_q : 8'h00;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight command without a response
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            cmd_rd_q     <= 1'b0;
            cmd_id_q     <= 1'b0;
            cap_q        <= 8'h00;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a1_q         <= 1'b0;
            a0_q         <= 1'b0;
            d_out_q      <= 8'h00;
            d_oe_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_id_q     <= cmd_id_d;
            cap_q        <= cap_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            a1_q         <= a1_d;
            a0_q         <= a0_d;
            d_out_q      <= d_out_d;
            d_oe_q       <= d_oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign ppi_cs_n  = cs_n_q;
    assign ppi_rd_n  = rd_n_q;
    assign ppi_wr_n  = wr_n_q;
    assign ppi_a1    = a1_q;
    assign ppi_a0    = a0_q;
    assign ppi_d_out = d_out_q;
    assign ppi_d_oe  = d_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// tb_ppi_bus_sequencer: table-driven vectors plus hand-written corner sequences
// for the PPI bus sequencer. Expected responses go into a scoreboard queue at
// acceptance and are popped when the design pulses rsp_valid.
module tb_ppi_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;

    // Instance A: default timing
    logic       req0_valid_a, req0_ready_a, req0_rd_a;
    logic [1:0] req0_addr_a;
    logic [7:0] req0_wdata_a;
    logic       req1_valid_a, req1_ready_a, req1_rd_a;
    logic [1:0] req1_addr_a;
    logic [7:0] req1_wdata_a;
    logic       rsp_valid_a, rsp_id_a, rsp_err_a;
    logic [7:0] rsp_rdata_a;
    logic       cs_n_a, rd_n_a, wr_n_a, a1_a, a0_a, d_oe_a, busy_a;
    logic [7:0] d_out_a, d_in_a;

    // Instance B: stretched timing
    logic       req0_valid_b, req0_ready_b, req1_ready_b;
    logic       rsp_valid_b, rsp_id_b, rsp_err_b;
    logic [7:0] rsp_rdata_b;
    logic       cs_n_b, rd_n_b, wr_n_b, a1_b, a0_b, d_oe_b, busy_b;
    logic [7:0] d_out_b;

    ppi_bus_sequencer dut_a (
        .clk(clk), .Reset(Reset),
        .req0_valid(req0_valid_a), .req0_ready(req0_ready_a), .req0_rd(req0_rd_a),
        .req0_addr(req0_addr_a), .req0_wdata(req0_wdata_a),
        .req1_valid(req1_valid_a), .req1_ready(req1_ready_a), .req1_rd(req1_rd_a),
        .req1_addr(req1_addr_a), .req1_wdata(req1_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a),
        .ppi_cs_n(cs_n_a), .ppi_rd_n(rd_n_a), .ppi_wr_n(wr_n_a), .ppi_a1(a1_a), .ppi_a0(a0_a),
        .ppi_d_out(d_out_a), .ppi_d_oe(d_oe_a), .ppi_d_in(d_in_a), .busy(busy_a)
    );

    ppi_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .clk(clk), .Reset(Reset),
        .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_rd(1'b0),
        .req0_addr(2'd3), .req0_wdata(8'h8A),
        .req1_valid(1'b0), .req1_ready(req1_ready_b), .req1_rd(1'b0),
        .req1_addr(2'd0), .req1_wdata(8'h00),
        .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
        .ppi_cs_n(cs_n_b), .ppi_rd_n(rd_n_b), .ppi_wr_n(wr_n_b), .ppi_a1(a1_b), .ppi_a0(a0_b),
        .ppi_d_out(d_out_b), .ppi_d_oe(d_oe_b), .ppi_d_in(8'h00), .busy(busy_b)
    );

    typedef struct {
        logic       id;
        logic       rd;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_cs;
        int         exp_rd_low;
        int         exp_wr_low;
        int         exp_oe;
    } vec_t;

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cs_low_cnt, rd_low_cnt, wr_low_cnt, oe_cnt, pin_err_cnt;
    logic rsp_seen;
    logic [1:0] cur_addr;
    logic [7:0] cur_wdata;
    logic [7:0] cur_din;

    // Compare one observed value against the bench's own expectation
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Advance one clock, sample instance A just after the edge and update the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!cs_n_a) cs_low_cnt++;
        if (!rd_n_a) rd_low_cnt++;
        if (!wr_n_a) wr_low_cnt++;
        if (d_oe_a) oe_cnt++;
        if (!cs_n_a && (({a1_a, a0_a} != cur_addr) || (d_oe_a && (d_out_a != cur_wdata)))) pin_err_cnt++;
        if ((!rd_n_a || !wr_n_a) && cs_n_a) pin_err_cnt++;
        if (!rd_n_a && !wr_n_a) pin_err_cnt++;
        d_in_a = !rd_n_a ? cur_din : 8'h5A;
        if (rsp_valid_a) begin
            rsp_seen = 1'b1;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_id", int'(rsp_id_a), int'(e.id));
                checkOutput("rsp_err", int'(rsp_err_a), int'(e.err));
                checkOutput("rsp_rdata", int'(rsp_rdata_a), int'(e.rdata));
                checkOutput("rsp_latency", cyc, e.due);
            end
        end
    endtask

    task automatic clearCounters();
        cs_low_cnt  = 0;
        rd_low_cnt  = 0;
        wr_low_cnt  = 0;
        oe_cnt      = 0;
        pin_err_cnt = 0;
        rsp_seen    = 1'b0;
    endtask

    task automatic pushExpected(input logic id, input logic rd, input logic [1:0] addr, input logic [7:0] din);
        exp_t e;
        e.id    = id;
        e.err   = rd && (addr == 2'd3);
        e.rdata = (rd && (addr != 2'd3)) ? din : 8'h00;
        e.due   = cyc + (e.err ? 1 : 5);
        sb.push_back(e);
    endtask

    // Drive one table vector from its requester and check response and pin activity
    task automatic applyStimulus(input vec_t v, input int idx);
        logic accepted;
        int   k;
        clearCounters();
        cur_addr  = v.addr;
        cur_wdata = v.wdata;
        cur_din   = v.din;
        if (v.id) begin
            req1_valid_a = 1'b1; req1_rd_a = v.rd; req1_addr_a = v.addr; req1_wdata_a = v.wdata;
        end else begin
            req0_valid_a = 1'b1; req0_rd_a = v.rd; req0_addr_a = v.addr; req0_wdata_a = v.wdata;
        end
        accepted = 1'b0;
        k = 0;
        while (!accepted && k < 20) begin
            #1;
            if (v.id ? req1_ready_a : req0_ready_a) begin
                pushExpected(v.id, v.rd, v.addr, v.din);
                accepted = 1'b1;
            end
            tick();
            k++;
        end
        checkOutput($sformatf("v%0d_accept", idx), int'(accepted), 1);
        req0_valid_a = 1'b0; req1_valid_a = 1'b0;
        req0_addr_a = ~v.addr; req1_addr_a = ~v.addr;
        req0_wdata_a = ~v.wdata; req1_wdata_a = ~v.wdata;
        k = 0;
        while (!rsp_seen && k < 20) begin
            tick();
            k++;
        end
        checkOutput($sformatf("v%0d_rsp_seen", idx), int'(rsp_seen), 1);
        checkOutput($sformatf("v%0d_cs_low", idx), cs_low_cnt, v.exp_cs);
        checkOutput($sformatf("v%0d_rd_low", idx), rd_low_cnt, v.exp_rd_low);
        checkOutput($sformatf("v%0d_wr_low", idx), wr_low_cnt, v.exp_wr_low);
        checkOutput($sformatf("v%0d_d_oe", idx), oe_cnt, v.exp_oe);
        checkOutput($sformatf("v%0d_pin_err", idx), pin_err_cnt, 0);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        int   grants[$];
        int   exp_grants[4];
        int   k;
        int   t0;
        int   b_wr_low;
        int   b_cs_low;
        logic got;

        vecs[0] = '{1'b0, 1'b0, 2'd3, 8'h80, 8'h00, 1'b0, 8'h00, 4, 0, 2, 4};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 8'h00, 8'hA5, 1'b0, 8'hA5, 4, 2, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1, 8'h00, 0, 0, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 8'h3C, 8'h00, 1'b0, 8'h00, 4, 0, 2, 4};
        vecs[4] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h96, 1'b0, 8'h96, 4, 2, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 8'h00, 8'hC3, 1'b0, 8'hC3, 4, 2, 0, 0};
        exp_grants = '{0, 1, 0, 1};

        Reset = 1'b1;
        req0_valid_a = 1'b0; req0_rd_a = 1'b0; req0_addr_a = 2'd0; req0_wdata_a = 8'h00;
        req1_valid_a = 1'b0; req1_rd_a = 1'b0; req1_addr_a = 2'd0; req1_wdata_a = 8'h00;
        req0_valid_b = 1'b0;
        d_in_a = 8'h5A;
        cur_addr = 2'd0; cur_wdata = 8'h00; cur_din = 8'h00;
        clearCounters();

        // Reset state, and ready held low while reset is asserted
        tick();
        tick();
        req0_valid_a = 1'b1;
        #1;
        checkOutput("reset_ready0", int'(req0_ready_a), 0);
        checkOutput("reset_cs_n", int'(cs_n_a), 1);
        checkOutput("reset_rd_n", int'(rd_n_a), 1);
        checkOutput("reset_wr_n", int'(wr_n_a), 1);
        checkOutput("reset_addr", int'({a1_a, a0_a}), 0);
        checkOutput("reset_d_out", int'(d_out_a), 0);
        checkOutput("reset_d_oe", int'(d_oe_a), 0);
        checkOutput("reset_rsp", int'({rsp_valid_a, rsp_id_a, rsp_err_a, rsp_rdata_a}), 0);
        checkOutput("reset_busy", int'(busy_a), 0);
        req0_valid_a = 1'b0;
        Reset = 1'b0;
        tick();

        // Table-driven single-requester commands
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
            tick();
        end

        // Both requesters valid continuously: alternating grants from reset
        doReset();
        clearCounters();
        req0_valid_a = 1'b1; req0_rd_a = 1'b0; req0_addr_a = 2'd1; req0_wdata_a = 8'h11;
        req1_valid_a = 1'b1; req1_rd_a = 1'b0; req1_addr_a = 2'd2; req1_wdata_a = 8'h22;
        k = 0;
        while (grants.size() < 4 && k < 60) begin
            #1;
            checkOutput("ready_onehot", int'(req0_ready_a & req1_ready_a), 0);
            if (req0_ready_a) begin
                grants.push_back(0);
                pushExpected(1'b0, 1'b0, 2'd1, 8'h00);
                cur_addr = 2'd1; cur_wdata = 8'h11;
            end else if (req1_ready_a) begin
                grants.push_back(1);
                pushExpected(1'b1, 1'b0, 2'd2, 8'h00);
                cur_addr = 2'd2; cur_wdata = 8'h22;
            end
            tick();
            k++;
        end
        req0_valid_a = 1'b0; req1_valid_a = 1'b0;
        checkOutput("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_grants[i]);
        end
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        checkOutput("t3_drained", sb.size(), 0);
        checkOutput("t3_pin_err", pin_err_cnt, 0);

        // Reset during the write strobe drops the command silently
        tick();
        clearCounters();
        cur_addr = 2'd0; cur_wdata = 8'h55;
        req0_valid_a = 1'b1; req0_rd_a = 1'b0; req0_addr_a = 2'd0; req0_wdata_a = 8'h55;
        got = 1'b0;
        k = 0;
        while (!got && k < 10) begin
            #1;
            if (req0_ready_a) begin
                pushExpected(1'b0, 1'b0, 2'd0, 8'h00);
                got = 1'b1;
            end
            tick();
            k++;
        end
        req0_valid_a = 1'b0;
        k = 0;
        while (wr_n_a && k < 10) begin
            tick();
            k++;
        end
        checkOutput("t5_in_strobe", int'(wr_n_a), 0);
        Reset = 1'b1;
        req1_valid_a = 1'b1;
        #1;
        checkOutput("t5_ready_in_reset", int'(req1_ready_a), 0);
        tick();
        sb.delete();
        checkOutput("t5_cs_n", int'(cs_n_a), 1);
        checkOutput("t5_wr_n", int'(wr_n_a), 1);
        checkOutput("t5_d_oe", int'(d_oe_a), 0);
        checkOutput("t5_busy", int'(busy_a), 0);
        checkOutput("t5_rsp_valid", int'(rsp_valid_a), 0);
        Reset = 1'b0;
        req1_valid_a = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        applyStimulus('{1'b1, 1'b0, 2'd3, 8'h07, 8'h00, 1'b0, 8'h00, 4, 0, 2, 4}, 6);

        // Stretched timing instance: SETUP=2, STROBE=3, HOLD=2
        b_wr_low = 0;
        b_cs_low = 0;
        t0 = 0;
        req0_valid_b = 1'b1;
        got = 1'b0;
        k = 0;
        while (!got && k < 10) begin
            #1;
            if (req0_ready_b) begin
                t0 = cyc;
                got = 1'b1;
            end
            tick();
            k++;
        end
        req0_valid_b = 1'b0;
        checkOutput("t6_accept", int'(got), 1);
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            if (!wr_n_b) b_wr_low++;
            if (!cs_n_b) b_cs_low++;
            if (rsp_valid_b) begin
                got = 1'b1;
                checkOutput("t6_latency", cyc - t0, 8);
                checkOutput("t6_rsp_id", int'(rsp_id_b), 0);
                checkOutput("t6_rsp_err", int'(rsp_err_b), 0);
            end else begin
                tick();
            end
            k++;
        end
        checkOutput("t6_rsp_seen", int'(got), 1);
        checkOutput("t6_wr_low", b_wr_low, 3);
        checkOutput("t6_cs_low", b_cs_low, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
